// File: rtl/draw_cmd_pkg.sv
// Shared definitions for the draw-command decoder: opcodes, header layout, FSM states.
package draw_cmd_pkg;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_SETREG   = 8'h01;
  localparam logic [7:0] OP_DRAW     = 8'h02;
  localparam logic [7:0] OP_WAITIDLE = 8'h03;

  localparam int unsigned HDR_OP_MSB   = 31;
  localparam int unsigned HDR_OP_LSB   = 24;
  localparam int unsigned HDR_ADDR_MSB = 15;
  localparam int unsigned HDR_ADDR_LSB = 8;
  localparam int unsigned HDR_CNT_MSB  = 7;
  localparam int unsigned HDR_CNT_LSB  = 0;

  typedef enum logic [2:0] {
    StIdle,
    StHdrWait,
    StArgReq,
    StArgWait,
    StEngWait
  } dec_state_e;

  function automatic logic [7:0] hdr_op(input logic [31:0] w);
    return w[HDR_OP_MSB:HDR_OP_LSB];
  endfunction

  function automatic logic [7:0] hdr_addr(input logic [31:0] w);
    return w[HDR_ADDR_MSB:HDR_ADDR_LSB];
  endfunction

  function automatic logic [7:0] hdr_cnt(input logic [31:0] w);
    return w[HDR_CNT_MSB:HDR_CNT_LSB];
  endfunction

endpackage

// File: rtl/draw_cmd_decoder.sv
// Drains the draw-command FIFO one word at a time, turning headers and argument words
// into register-write strobes and draw-start pulses.
module draw_cmd_decoder #(
  parameter int unsigned REG_AW = 8
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              INIT,
  input  logic              DEC_EN,
  input  logic              EMPTY_DEC,
  input  logic [31:0]       OUTDATA,
  input  logic              DATAVALID,
  output logic              BUF_RD,
  output logic              REG_WE,
  output logic [REG_AW-1:0] REG_ADDR,
  output logic [31:0]       REG_WDATA,
  input  logic              DRAW_BUSY,
  output logic              DRAW_START,
  output logic              DEC_BUSY,
  output logic              ERR_CMD,
  output logic              ERR_RD
);
  import draw_cmd_pkg::*;

  dec_state_e        state_q, state_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              is_draw_q, is_draw_d;
  logic              reg_we_q, reg_we_d;
  logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
  logic [31:0]       reg_wdata_q, reg_wdata_d;
  logic              draw_start_q, draw_start_d;
  logic              err_cmd_q, err_cmd_d;
  logic              err_rd_q, err_rd_d;
  logic              buf_rd;
  logic [7:0]        op;

  assign op = hdr_op(OUTDATA);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    is_draw_d    = is_draw_q;
    reg_we_d     = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    draw_start_d = 1'b0;
    err_cmd_d    = err_cmd_q;
    err_rd_d     = err_rd_q;
    buf_rd       = 1'b0;

    case (state_q)
      StIdle: begin
        if (DEC_EN && !EMPTY_DEC) begin
          buf_rd  = 1'b1;
          state_d = StHdrWait;
        end
      end
      StHdrWait: begin
        if (!DATAVALID) begin
          err_rd_d = 1'b1;
          state_d  = StIdle;
        end else begin
          case (op)
            OP_NOP: state_d = StIdle;
            OP_SETREG: begin
              addr_d  = REG_AW'(hdr_addr(OUTDATA));
              cnt_d   = hdr_cnt(OUTDATA);
              state_d = (hdr_cnt(OUTDATA) != 8'd0) ? StArgReq : StIdle;
            end
            OP_DRAW, OP_WAITIDLE: begin
              is_draw_d = (op == OP_DRAW);
              // Engine already idle: finish now so DRAW_START lands the cycle after decode.
              if (!DRAW_BUSY) begin
                draw_start_d = (op == OP_DRAW);
                state_d      = StIdle;
              end else begin
                state_d = StEngWait;
              end
            end
            default: begin
              err_cmd_d = 1'b1;
              state_d   = StIdle;
            end
          endcase
        end
      end
      StArgReq: begin
        if (!EMPTY_DEC) begin
          buf_rd  = 1'b1;
          state_d = StArgWait;
        end
      end
      StArgWait: begin
        if (DATAVALID) begin
          reg_we_d    = 1'b1;
          reg_addr_d  = addr_q;
          reg_wdata_d = OUTDATA;
          addr_d      = addr_q + REG_AW'(1);
          cnt_d       = cnt_q - 8'd1;
          state_d     = (cnt_q > 8'd1) ? StArgReq : StIdle;
        end else begin
          err_rd_d = 1'b1;
          state_d  = StIdle;
        end
      end
      StEngWait: begin
        if (!DRAW_BUSY) begin
          draw_start_d = is_draw_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // INIT overrides whatever the FSM decided this cycle, including a pending pop.
    if (INIT) begin
      state_d      = StIdle;
      addr_d       = '0;
      cnt_d        = 8'd0;
      is_draw_d    = 1'b0;
      reg_we_d     = 1'b0;
      reg_addr_d   = '0;
      reg_wdata_d  = 32'd0;
      draw_start_d = 1'b0;
      err_cmd_d    = 1'b0;
      err_rd_d     = 1'b0;
      buf_rd       = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      cnt_q        <= 8'd0;
      is_draw_q    <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= 32'd0;
      draw_start_q <= 1'b0;
      err_cmd_q    <= 1'b0;
      err_rd_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      is_draw_q    <= is_draw_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      draw_start_q <= draw_start_d;
      err_cmd_q    <= err_cmd_d;
      err_rd_q     <= err_rd_d;
    end
  end

  // The read strobe is combinational, so gate it with reset to keep every output low
  // while RST_X is held.
  assign BUF_RD     = buf_rd & RST_X;
  assign REG_WE     = reg_we_q;
  assign REG_ADDR   = reg_addr_q;
  assign REG_WDATA  = reg_wdata_q;
  assign DRAW_START = draw_start_q;
  assign DEC_BUSY   = (state_q != StIdle);
  assign ERR_CMD    = err_cmd_q;
  assign ERR_RD     = err_rd_q;

endmodule
